or1200_keccak_seq: RTL

Sequencer between the EX-stage `l.cust5` decode of the or1200 control unit and the Keccak permutation core. It absorbs 32-bit operand words issued by start/middle/end custom instructions and runs the round counter for the permutation. It serves store instructions by reading output words from the core and returning them on the register-file write-back path. It also stalls the pipeline while a permutation is in flight.

---
 rtl/or1200_keccak_seq_if.sv | 34 +++
 rtl/or1200_keccak_seq.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/or1200_keccak_seq_if.sv
// Pipeline/core-facing signal bundle for the l.cust5 Keccak sequencer.
// The slave modport is the sequencer; the master side is the pipeline plus permutation core.
interface or1200_keccak_seq_if;
  logic        ex_freeze;
  logic        cust5_valid;
  logic [4:0]  cust5_op;
  logic [5:0]  cust5_limm;
  logic [31:0] operand_a;
  logic        cust5_stall;
  logic        core_load;
  logic [4:0]  core_idx;
  logic [31:0] core_word;
  logic        core_clr;
  logic        core_round_en;
  logic [4:0]  core_round;
  logic [3:0]  core_rd_idx;
  logic [31:0] core_rd_data;
  logic [31:0] rf_dataw;
  logic        rf_we;
  logic        busy;
  logic        err;

  modport slave (
    input  ex_freeze, cust5_valid, cust5_op, cust5_limm, operand_a, core_rd_data,
    output cust5_stall, core_load, core_idx, core_word, core_clr, core_round_en,
           core_round, core_rd_idx, rf_dataw, rf_we, busy, err
  );

  modport master (
    output ex_freeze, cust5_valid, cust5_op, cust5_limm, operand_a, core_rd_data,
    input  cust5_stall, core_load, core_idx, core_word, core_clr, core_round_en,
           core_round, core_rd_idx, rf_dataw, rf_we, busy, err
  );
endinterface

// File: rtl/or1200_keccak_seq.sv
// Sequencer between l.cust5 decode and the Keccak core: absorbs words, runs rounds, serves stores.
// state   | meaning
// IDLE    | after reset, nothing absorbed
// ABSORB  | collecting operand words into the core input slots
// PERMUTE | one round per cycle, start/store held off by stall
// DONE    | output words readable by stores
module or1200_keccak_seq #(
  parameter int WORDS_IN  = 18,
  parameter int ROUNDS    = 24,
  parameter int OUT_WORDS = 16
) (
  input logic                clk,
  input logic                rst,
  or1200_keccak_seq_if.slave bus
);
  localparam logic [4:0] OP_START = 5'b00100;
  localparam logic [4:0] OP_MID   = 5'b00010;
  localparam logic [4:0] OP_END   = 5'b00001;
  localparam logic [4:0] OP_STORE = 5'b01000;
  localparam logic [4:0] CNT_MAX  = 5'(WORDS_IN);
  localparam logic [4:0] RND_LAST = 5'(ROUNDS - 1);
  localparam logic [5:0] OUT_LIM  = 6'(OUT_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_ABSORB, S_PERMUTE, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d, round_q, round_d, idx_q, idx_d;
  logic [31:0] word_q, word_d, dataw_q, dataw_d;
  logic        load_q, load_d, clr_q, clr_d, we_q, we_d, err_q, err_d;
  logic        stall, busy, acc;
  logic        op_start, op_mid, op_end, op_store;

  assign op_start = (bus.cust5_op == OP_START);
  assign op_mid   = (bus.cust5_op == OP_MID);
  assign op_end   = (bus.cust5_op == OP_END);
  assign op_store = (bus.cust5_op == OP_STORE);
  assign acc      = bus.cust5_valid & ~bus.ex_freeze & ~stall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (acc) begin
      case (state_q)
        S_IDLE, S_DONE: if (op_start) state_d = S_ABSORB;
        S_ABSORB: begin
          if (op_end) state_d = S_PERMUTE;
        end
        default: ;
      endcase
    end
    if (state_q == S_PERMUTE && round_q == RND_LAST) state_d = S_DONE;
  end

  // Middle/end during a permutation are accepted (and flagged); only start/store must wait.
  always_comb begin
    stall = 1'b0;
    busy  = 1'b0;
    if (state_q == S_PERMUTE) begin
      busy  = 1'b1;
      stall = bus.cust5_valid & (op_start | op_store);
    end
  end

  always_comb begin
    cnt_d   = cnt_q;
    round_d = round_q;
    err_d   = err_q;
    load_d  = 1'b0;
    clr_d   = 1'b0;
    idx_d   = idx_q;
    word_d  = word_q;
    we_d    = 1'b0;
    dataw_d = dataw_q;
    if (state_q == S_PERMUTE) round_d = (round_q == RND_LAST) ? 5'd0 : round_q + 5'd1;
    if (acc) begin
      if (op_start) begin
        clr_d  = 1'b1;
        load_d = 1'b1;
        idx_d  = 5'd0;
        word_d = bus.operand_a;
        cnt_d  = 5'd1;
        err_d  = 1'b0;
      end else if (op_mid || op_end) begin
        if (state_q == S_ABSORB) begin
          if (cnt_q < CNT_MAX) begin
            load_d = 1'b1;
            idx_d  = cnt_q;
            word_d = bus.operand_a;
            if (op_mid) cnt_d = cnt_q + 5'd1;
          end else begin
            err_d = 1'b1;
          end
          if (op_end) round_d = 5'd0;
        end else begin
          err_d = 1'b1;
        end
      end else if (op_store) begin
        we_d = 1'b1;
        if (state_q == S_DONE && bus.cust5_limm < OUT_LIM) dataw_d = bus.core_rd_data;
        else                                                dataw_d = 32'd0;
        if (state_q != S_DONE) err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= 5'd0;
      round_q <= 5'd0;
      err_q   <= 1'b0;
      load_q  <= 1'b0;
      clr_q   <= 1'b0;
      idx_q   <= 5'd0;
      word_q  <= 32'd0;
      we_q    <= 1'b0;
      dataw_q <= 32'd0;
    end else begin
      cnt_q   <= cnt_d;
      round_q <= round_d;
      err_q   <= err_d;
      load_q  <= load_d;
      clr_q   <= clr_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      we_q    <= we_d;
      dataw_q <= dataw_d;
    end
  end

  assign bus.cust5_stall   = stall;
  assign bus.busy          = busy;
  assign bus.core_round_en = busy;
  assign bus.core_round    = round_q;
  assign bus.core_load     = load_q;
  assign bus.core_idx      = idx_q;
  assign bus.core_word     = word_q;
  assign bus.core_clr      = clr_q;
  assign bus.core_rd_idx   = bus.cust5_limm[3:0];
  assign bus.rf_dataw      = dataw_q;
  assign bus.rf_we         = we_q;
  assign bus.err           = err_q;
endmodule
